// File: rtl/pattern_order_sequencer_pkg.sv
// pattern_order_pkg: shared types and constants for the pattern order sequencer.
//   state_t         - sequencer FSM states
//   ADDR_W / LEN_W  - per-channel start address / pattern length field widths
//   CH_FIELD_W      - per-channel field stride inside an order entry
//   END_MARKER_DUR  - duration value that marks end of song
//   addr_lsb/len_lsb - bit offsets of channel fields within an order entry
package pattern_order_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ARMED,
        PLAYING
    } state_t;

    localparam int ADDR_W         = 5;
    localparam int LEN_W          = 5;
    localparam int CH_FIELD_W     = ADDR_W + LEN_W;
    localparam int END_MARKER_DUR = 0;

    // Entry layout: duration in the LSBs, then {len, addr} per channel, ch0 first.
    function automatic int addr_lsb(input int dur_w, input int ch);
        return dur_w + ch * CH_FIELD_W;
    endfunction

    function automatic int len_lsb(input int dur_w, input int ch);
        return addr_lsb(dur_w, ch) + ADDR_W;
    endfunction

endpackage

// File: rtl/pattern_order_sequencer_unpack.sv
// order_entry_unpack: combinational slicing of one order-list entry.
// Ports:
//   entry - raw order entry (duration + per-channel fields)
//   dur   - pattern duration in note strobes
//   addr  - per-channel pattern start address, ch0 in LSBs
//   len   - per-channel pattern length, ch0 in LSBs
module order_entry_unpack
    import pattern_order_pkg::*;
#(
    parameter  int NUM_CH  = 3,
    parameter  int DUR_W   = 8,
    localparam int ENTRY_W = DUR_W + NUM_CH * CH_FIELD_W
) (
    input  logic [ENTRY_W-1:0]       entry,
    output logic [DUR_W-1:0]         dur,
    output logic [NUM_CH*ADDR_W-1:0] addr,
    output logic [NUM_CH*LEN_W-1:0]  len
);

    assign dur = entry[DUR_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign addr[c*ADDR_W +: ADDR_W] = entry[addr_lsb(DUR_W, c) +: ADDR_W];
        assign len[c*LEN_W +: LEN_W]    = entry[len_lsb(DUR_W, c) +: LEN_W];
    end

endmodule

// File: rtl/pattern_order_sequencer.sv
// pattern_order_sequencer: song-level controller for a bank of note_sequencer
// channels. Walks an order-list ROM, prefetches the next entry while the current
// pattern plays, and broadcasts a reload request at each pattern boundary.
// Optional build macro: ORDER_SEQ_LOOP_CNT_EN (saturating end-of-song loop counter).
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_start / i_stop    - begin playback at position 0 / halt playback
//   i_note_stb          - tick strobe shared with all channels
//   i_loop_pos          - order position to jump to on an end marker
//   o_order_addr        - order ROM address; i_order_data valid one clock later
//   o_new_addr          - per-channel start address of the next pattern
//   o_new_pattern_len   - per-channel length of the next pattern
//   o_new_addr_valid    - reload request; channels reload on valid & i_note_stb
//   o_playing           - high whenever the sequencer is not idle
//   o_order_pos         - order position of the pattern now playing
//   o_error             - sticky; loop target was itself an end marker
//   o_loop_count        - end-marker jumps since start (0 unless macro defined)
module pattern_order_sequencer
    import pattern_order_pkg::*;
#(
    parameter  int NUM_CH   = 3,
    parameter  int ORDER_AW = 6,
    parameter  int DUR_W    = 8,
    localparam int ENTRY_W  = DUR_W + NUM_CH * CH_FIELD_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_note_stb,
    input  logic [ORDER_AW-1:0]       i_loop_pos,
    output logic [ORDER_AW-1:0]       o_order_addr,
    input  logic [ENTRY_W-1:0]        i_order_data,
    output logic [NUM_CH*ADDR_W-1:0]  o_new_addr,
    output logic [NUM_CH*LEN_W-1:0]   o_new_pattern_len,
    output logic                      o_new_addr_valid,
    output logic                      o_playing,
    output logic [ORDER_AW-1:0]       o_order_pos,
    output logic                      o_error,
    output logic [7:0]                o_loop_count
);

    state_t              state;
    logic [ORDER_AW-1:0] pos;
    logic [ORDER_AW-1:0] order_pos;
    logic [DUR_W-1:0]    count;
    logic [ENTRY_W-1:0]  shadow;
    logic [DUR_W-1:0]    shadow_dur;
    logic [DUR_W-1:0]    data_dur;
    logic                jumped;
    logic                error;
    logic                valid;
    logic                is_marker;
    logic                start_go;
    logic                jump_go;

    order_entry_unpack #(
        .NUM_CH (NUM_CH),
        .DUR_W  (DUR_W)
    ) u_unpack (
        .entry (shadow),
        .dur   (shadow_dur),
        .addr  (o_new_addr),
        .len   (o_new_pattern_len)
    );

    assign data_dur  = i_order_data[DUR_W-1:0];
    assign is_marker = (data_dur == DUR_W'(END_MARKER_DUR));
    assign start_go  = (state == IDLE) && i_start && !i_stop;
    assign jump_go   = (state == LATCH) && !i_stop && is_marker && !jumped;

    // count holds the strobes still owed by the current pattern after the
    // boundary strobe; strobes during a prefetch are still counted, and a
    // prefetch that completes with count already 0 arms immediately.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            pos       <= '0;
            order_pos <= '0;
            count     <= '0;
            shadow    <= '0;
            jumped    <= 1'b0;
            error     <= 1'b0;
            valid     <= 1'b0;
        end else if (i_stop) begin
            state <= IDLE;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_go) begin
                        state  <= FETCH;
                        pos    <= '0;
                        count  <= '0;
                        jumped <= 1'b0;
                        error  <= 1'b0;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                    if (i_note_stb && count != '0) count <= count - 1'b1;
                end
                LATCH: begin
                    shadow <= i_order_data;
                    if (i_note_stb && count != '0) count <= count - 1'b1;
                    if (jump_go) begin
                        pos    <= i_loop_pos;
                        jumped <= 1'b1;
                        state  <= FETCH;
                    end else if (is_marker) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else if (count == '0) begin
                        jumped <= 1'b0;
                        state  <= ARMED;
                        valid  <= 1'b1;
                    end else begin
                        jumped <= 1'b0;
                        state  <= PLAYING;
                    end
                end
                ARMED: begin
                    if (i_note_stb) begin
                        count     <= shadow_dur - 1'b1;
                        order_pos <= pos;
                        pos       <= pos + 1'b1;
                        jumped    <= 1'b0;
                        state     <= FETCH;
                    end else begin
                        valid <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (count == '0) begin
                        state <= ARMED;
                        valid <= 1'b1;
                    end else if (i_note_stb) begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_order_addr     = pos;
    assign o_new_addr_valid = valid;
    assign o_playing        = (state != IDLE);
    assign o_order_pos      = order_pos;
    assign o_error          = error;

`ifdef ORDER_SEQ_LOOP_CNT_EN
    logic [7:0] loop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            loop_cnt <= '0;
        end else if (start_go) begin
            loop_cnt <= '0;
        end else if (jump_go && loop_cnt != 8'hFF) begin
            loop_cnt <= loop_cnt + 8'd1;
        end
    end

    assign o_loop_count = loop_cnt;
`else
    assign o_loop_count = '0;
`endif

endmodule

// File: tb/tb_pattern_order_sequencer.sv
module tb_pattern_order_sequencer;

    localparam int NUM_CH   = 3;
    localparam int ORDER_AW = 6;
    localparam int DUR_W    = 8;
    localparam int ENTRY_W  = DUR_W + NUM_CH * 10;
    localparam int DEPTH    = 64;

    logic                   clk = 1'b0;
    logic                   rst, start, stop, stb;
    logic [ORDER_AW-1:0]    loop_pos, order_addr, order_pos;
    logic [ENTRY_W-1:0]     order_data;
    logic [NUM_CH*5-1:0]    new_addr, new_len;
    logic                   valid, playing, error;
    logic [7:0]             loop_count;

    always #5 clk = ~clk;

    pattern_order_sequencer #(
        .NUM_CH   (NUM_CH),
        .ORDER_AW (ORDER_AW),
        .DUR_W    (DUR_W)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_stop            (stop),
        .i_note_stb        (stb),
        .i_loop_pos        (loop_pos),
        .o_order_addr      (order_addr),
        .i_order_data      (order_data),
        .o_new_addr        (new_addr),
        .o_new_pattern_len (new_len),
        .o_new_addr_valid  (valid),
        .o_playing         (playing),
        .o_order_pos       (order_pos),
        .o_error           (error),
        .o_loop_count      (loop_count)
    );

    // Order ROM with one clock read latency.
    logic [ENTRY_W-1:0] rom [DEPTH];
    always @(posedge clk) order_data <= rom[order_addr];

    typedef struct packed {
        int                 pos;
        int                 dur;
        int                 jumps;
        logic [ENTRY_W-1:0] entry;
    } exp_t;

    exp_t model_q[$];
    exp_t sb_q[$];
    bit   model_err;
    int   model_err_jumps;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int reloads, stb_since, cur_d, last_stb_cyc, cyc, exp_pos;
    bit pend_pos, prev_valid;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic logic [ENTRY_W-1:0] mk(input int d, input int a0, input int a1, input int a2,
                                              input int l0, input int l1, input int l2);
        return {5'(l2), 5'(a2), 5'(l1), 5'(a1), 5'(l0), 5'(a0), 8'(d)};
    endfunction

    // Song walk: list of entries presented at successive boundaries, from
    // position 0, following end markers to the loop target.
    function automatic void build_model(input int lp);
        int   p = 0;
        int   jumps = 0;
        bit   j;
        exp_t e;
        model_q.delete();
        model_err = 0;
        model_err_jumps = 0;
        for (int k = 0; k < DEPTH; k++) begin
            j = 0;
            while (rom[p][DUR_W-1:0] == 0) begin
                if (j) begin
                    model_err = 1;
                    model_err_jumps = jumps;
                    return;
                end
                p = lp;
                jumps++;
                j = 1;
            end
            e.pos = p;
            e.dur = int'(rom[p][DUR_W-1:0]);
            e.jumps = jumps;
            e.entry = rom[p];
            model_q.push_back(e);
            p = (p + 1) % DEPTH;
        end
    endfunction

    // Reload k happens on strobe number 1 + sum of the previous durations.
    function automatic int exp_reloads(input int s);
        int sum = 0;
        int n = 0;
        foreach (model_q[k]) begin
            if (sum < s) n++;
            sum += model_q[k].dur;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; stop = 0; stb = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    endtask

    task automatic run_song(input int lp, input int nstb, input int gmin, input int gmax);
        int r, exp_lc;
        bit exp_err;
        build_model(lp);
        loop_pos = ORDER_AW'(lp);
        sb_q = model_q;
        cur_d = 0; stb_since = 0; reloads = 0;
        start = 1; tick(); start = 0;
        repeat (6) tick();
        for (int i = 0; i < nstb; i++) begin
            stb = 1; tick(); stb = 0;
            repeat ($urandom_range(gmax, gmin) - 1) tick();
        end
        repeat (8) tick();
        r = exp_reloads(nstb);
        exp_err = model_err && (r == model_q.size());
        check("reload_cnt", reloads, r);
        check("error", error, exp_err);
        check("playing", playing, !exp_err);
        if (r > 0) check("end_order_pos", order_pos, model_q[r-1].pos);
        exp_lc = (r < model_q.size()) ? model_q[r].jumps : model_err_jumps;
        if (exp_lc > 255) exp_lc = 255;
`ifdef ORDER_SEQ_LOOP_CNT_EN
        check("loop_count", loop_count, exp_lc);
`else
        check("loop_count", loop_count, 0);
`endif
    endtask

    task automatic stop_and_check();
        stop = 1; tick(); stop = 0;
        check("stop_playing", playing, 0);
        check("stop_valid", valid, 0);
    endtask

    // Scoreboard monitor: every reload the channels would see (valid & strobe)
    // pops one expected entry; strobe counts check pattern lengths.
    initial begin : monitor
        exp_t e;
        logic [NUM_CH*5-1:0] ea, el;
        cyc = 0; pend_pos = 0; prev_valid = 0; last_stb_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend_pos = 0;
                prev_valid = 0;
            end else begin
                if (pend_pos) begin
                    check("order_pos", order_pos, exp_pos);
                    pend_pos = 0;
                end
                if (valid && !prev_valid && cur_d >= 2)
                    check("rise_latency", cyc - last_stb_cyc, 2);
                if (stb && !stop) begin
                    last_stb_cyc = cyc;
                    if (valid) begin
                        if (sb_q.size() == 0) begin
                            check("sb_underflow", 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            for (int c = 0; c < NUM_CH; c++) begin
                                ea[c*5 +: 5] = e.entry[DUR_W + 10*c +: 5];
                                el[c*5 +: 5] = e.entry[DUR_W + 10*c + 5 +: 5];
                            end
                            check("new_addr", new_addr, ea);
                            check("new_len", new_len, el);
                            if (cur_d != 0) check("pattern_strobes", stb_since, cur_d);
                            cur_d = e.dur;
                            stb_since = 1;
                            exp_pos = e.pos;
                            pend_pos = 1;
                            reloads++;
                        end
                    end else if (playing) begin
                        stb_since++;
                        check("missed_boundary", stb_since <= cur_d, 1);
                    end
                end
                prev_valid = valid;
            end
        end
    end

    initial begin : driver
        int len;
        int lp;
        clear_rom();
        rst = 1; start = 0; stop = 0; stb = 0; loop_pos = '0;
        do_reset();

        // Reset state
        check("rst_valid", valid, 0);
        check("rst_playing", playing, 0);
        check("rst_order_pos", order_pos, 0);
        check("rst_order_addr", order_addr, 0);
        check("rst_error", error, 0);
        check("rst_loop_count", loop_count, 0);
        check("rst_new_addr", new_addr, 0);
        check("rst_new_len", new_len, 0);

        // Start together with stop from IDLE stays idle
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        check("startstop_playing", playing, 0);
        repeat (3) tick();
        check("startstop_playing2", playing, 0);
        check("startstop_addr", order_addr, 0);

        // Directed song with end-of-song loop back to entry 1
        clear_rom();
        rom[0] = mk(3, 4, 8, 12, 2, 3, 4);
        rom[1] = mk(2, 1, 2, 3, 5, 6, 7);
        run_song(1, 12, 4, 6);
        stop_and_check();

        // Stop in ARMED with a strobe on the same clock
        run_song(1, 3, 4, 4);
        check("armed_before_stop", valid, 1);
        stb = 1; stop = 1; tick(); stb = 0; stop = 0;
        check("stopstb_playing", playing, 0);
        check("stopstb_valid", valid, 0);
        check("stopstb_order_pos", order_pos, 0);
        tick();
        check("stopstb_reloads", reloads, 1);
        check("stopstb_order_pos2", order_pos, 0);

        // Reset in the middle of a pattern
        run_song(1, 1, 4, 4);
        rst = 1; tick();
        check("midrst_valid", valid, 0);
        check("midrst_playing", playing, 0);
        check("midrst_order_pos", order_pos, 0);
        check("midrst_order_addr", order_addr, 0);
        check("midrst_error", error, 0);
        check("midrst_loop_count", loop_count, 0);
        check("midrst_new_addr", new_addr, 0);
        check("midrst_new_len", new_len, 0);
        rst = 0; tick();

        // One-strobe patterns with the minimum strobe gap
        clear_rom();
        rom[0] = mk(1, 3, 5, 7, 9, 11, 13);
        rom[1] = mk(2, 17, 19, 21, 23, 25, 27);
        rom[2] = mk(1, 29, 31, 2, 4, 6, 8);
        rom[3] = mk(3, 10, 12, 14, 16, 18, 20);
        run_song(0, 14, 4, 4);
        stop_and_check();

        // Loop target is itself an end marker
        clear_rom();
        rom[0] = mk(2, 1, 1, 1, 2, 2, 2);
        run_song(2, 3, 4, 5);
        check("err_valid", valid, 0);

        // Randomized songs; the last one loops onto its own end marker
        for (int it = 0; it < 5; it++) begin
            clear_rom();
            len = $urandom_range(10, 3);
            for (int p = 0; p < len; p++)
                rom[p] = mk($urandom_range(9, 2), $urandom_range(31, 0), $urandom_range(31, 0),
                            $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                            $urandom_range(31, 0));
            lp = (it == 4) ? len : $urandom_range(len - 1, 0);
            run_song(lp, $urandom_range(40, 10), 4, 8);
            stop_and_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_order_sequencer.md
Name: pattern_order_sequencer

Overview:
Song-level controller for a bank of note_sequencer channels. It walks an order-list ROM where each entry holds a pattern duration plus, per channel, a pattern start address and pattern length. At each pattern boundary it presents the new address, length and a valid flag so every channel reloads on the same i_note_stb. It handles end-of-song looping and one-entry prefetch.

Parameters:
NUM_CH, 3, number of note_sequencer channels driven
ORDER_AW, 6, order ROM address width
DUR_W, 8, pattern duration width, in note strobes
ENTRY_W, DUR_W+NUM_CH*10, order entry width; derived, not overridable

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  pulse; begin playback at order position 0
i_stop  in  1  pulse; halt playback
i_note_stb  in  1  tick strobe, shared with all channels
i_loop_pos  in  ORDER_AW  order position to jump to on end marker
o_order_addr  out  ORDER_AW  order ROM address
i_order_data  in  ENTRY_W  ROM data, valid 1 clk after address
o_new_addr  out  NUM_CH*5  per-channel start address, ch0 in LSBs
o_new_pattern_len  out  NUM_CH*5  per-channel pattern length
o_new_addr_valid  out  1  broadcast reload request to all channels
o_playing  out  1  high in any state other than IDLE
o_order_pos  out  ORDER_AW  position of the pattern now playing
o_error  out  1  sticky; loop target is itself an end marker
o_loop_count  out  8  see Optional Feature

Behaviour:
- Entry layout: [DUR_W-1:0] duration D. Then per channel c, starting at bit DUR_W+10c: start address (5b), then length (5b). D==0 is the end marker.
- Reset: state IDLE. All outputs 0, position register 0, shadow entry cleared, o_error cleared.
- States and transitions:
  - IDLE → FETCH on i_start. Position is set to 0 and o_error is cleared.
  - FETCH: drive o_order_addr = position. Next cycle → LATCH.
  - LATCH: capture i_order_data into the shadow register.
    - If D==0 and no jump has been taken yet for this fetch: position ← i_loop_pos, → FETCH.
    - If D==0 a second time in the same fetch: set o_error, → IDLE.
    - Otherwise → ARMED if the current pattern has run out (or this is the first pattern), else → PLAYING.
  - ARMED: o_new_addr_valid=1. o_new_addr and o_new_pattern_len come from the shadow register.
    - On i_note_stb (boundary strobe): counter ← D-1, o_order_pos ← position, position ← position+1 (wraps modulo 2^ORDER_AW), → FETCH (prefetch of the next entry).
  - PLAYING: each i_note_stb decrements the counter. When the counter is already 0, → ARMED on the next clk instead of decrementing.
  - Prefetch completes while the pattern runs. A prefetch finishing with the counter already 0 goes straight to ARMED.
- Boundary timing: the boundary strobe counts as tick 1 of the pattern. A pattern with D=N occupies exactly N strobes, and valid rises 1 clk after the Nth strobe.
- D=1 is legal: valid is high for the strobe immediately after the boundary strobe.
- Strobe spacing: the minimum i_note_stb gap is 4 clks; the bench must honour it. A strobe seen in FETCH/LATCH is counted (decrement) but never misses the boundary.
- Valid outside ARMED is 0. o_new_* hold the shadow value whenever valid is 1; otherwise they are don't-care but are driven from the shadow register.
- i_stop, or i_stop together with i_start: → IDLE next clk, valid 0, o_order_pos held.
- i_start while not IDLE: ignored.
- i_rst mid-operation overrides everything. The state after reset equals the reset values.

Optional Feature:
Macro ORDER_SEQ_LOOP_CNT_EN.
- Defined: o_loop_count increments on each end-marker jump. It saturates at 255 and is cleared on i_start.
- Undefined: o_loop_count is tied to 0 and no counter logic is built.

Decomposition:
- Package pattern_order_pkg holds:
  - the state enum (IDLE, FETCH, LATCH, ARMED, PLAYING)
  - field width constants (ADDR_W=5, LEN_W=5, CH_FIELD_W=10)
  - the END_MARKER_DUR=0 constant
  - channel field offset functions
- One natural sub-module, order_entry_unpack: combinational slicing of the shadow entry into per-channel address/length vectors. All sequencing stays in the top.

Test Plan:
- Reset, then i_start with entries {D=3,a=4/8/12,l=2/3/4}, {D=2,...}: valid rises 1 clk after start's fetch completes. The first strobe reloads (o_order_pos=0). Valid rises again 1 clk after the 3rd strobe, and the pattern-1 values are presented.
- Entry 2 = end marker, i_loop_pos=1: after pattern 1 the next entry presented is entry 1, and o_loop_count=1 when the macro is defined.
- D=1 entry followed by D=2 with a 4-clk strobe gap: valid is held for the strobe right after the boundary strobe, with no missed boundary.
- End marker with i_loop_pos pointing at another end marker: o_error=1, o_playing=0, valid 0.
- i_stop asserted in ARMED with a strobe on the same clk: no reload is counted, and the next state is IDLE. i_rst mid-PLAYING: all outputs 0 next clk.
- i_start and i_stop in the same clk from IDLE: the block stays IDLE and o_playing stays 0.
